// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bundle for the EX-stage ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00110;
  localparam logic [4:0] OP_SUB = 5'b00111;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_OR  = 5'b01011;
  localparam logic [4:0] OP_SHL = 5'b01100;
  localparam logic [4:0] OP_SHR = 5'b01101;
  localparam logic [4:0] OP_CMP = 5'b01110;
  localparam logic [4:0] OP_NOT = 5'b01111;
  localparam logic [4:0] OP_NOP = 5'b11111;

  typedef enum logic [1:0] {
    IDLE,
    RUN_MUL,
    RUN_DIV,
    DONE
  } state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: shift-add multiply / restoring divide,
// one bit per step, WIDTH steps per operation.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] res
);

  localparam logic [SHAMT_W-1:0] LAST_CNT =
    SHAMT_W'(WIDTH - 1);

  logic               mode;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic [SHAMT_W-1:0] cnt;

  // div: acc = remainder, x = dividend/quotient, y = divisor
  // mul: acc = product, x = multiplicand, y = multiplier
  logic [WIDTH:0]   sh;
  logic             ge;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sh   = {acc, x[WIDTH-1]};
    ge   = (sh >= {1'b0, y});
    diff = sh[WIDTH-1:0] - y;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode <= 1'b0;
      acc  <= '0;
      x    <= '0;
      y    <= '0;
      cnt  <= '0;
    end else if (start) begin
      mode <= is_div;
      acc  <= '0;
      x    <= a;
      y    <= b;
      cnt  <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (mode) begin
        acc <= ge ? diff : sh[WIDTH-1:0];
        x   <= {x[WIDTH-2:0], ge};
      end else begin
        if (y[0])
          acc <= acc + x;
        x <= x << 1;
        y <= y >> 1;
      end
    end
  end

  assign last = (cnt == LAST_CNT);
  assign res  = mode ? x : acc;

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU with valid/ready handshake and iterative MUL/DIV.
// ALU_FAST_MUL_EN: single-cycle combinational multiply.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam int M = WIDTH - 1;

  state_t state;
  flags_t flg;
  logic   accept;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] sc_res;
  flags_t           sc_f;
  logic             sc_dbz;
  logic             sc_ill;
  logic             zn_en;
  logic             start_mul;
  logic             start_div;

  logic             eng_step;
  logic             eng_last;
  logic [WIDTH-1:0] eng_res;

  assign op_ready = (state == IDLE) &&
                    (!result_valid || result_ready);
  assign accept   = op_valid && op_ready;

  assign add_w = {1'b0, operand_a} + {1'b0, operand_b};
  assign sub_w = {1'b0, operand_a} - {1'b0, operand_b};

  always_comb begin
    sc_res    = '0;
    sc_f      = '0;
    sc_dbz    = 1'b0;
    sc_ill    = 1'b0;
    zn_en     = 1'b1;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (alu_control)
      OP_ADD: begin
        sc_res = add_w[M:0];
        sc_f.c = add_w[WIDTH];
        sc_f.v = (operand_a[M] == operand_b[M]) &&
                 (add_w[M] != operand_a[M]);
      end
      OP_SUB, OP_CMP: begin
        sc_res = sub_w[M:0];
        sc_f.c = ~sub_w[WIDTH];
        sc_f.v = (operand_a[M] != operand_b[M]) &&
                 (sub_w[M] != operand_a[M]);
      end
      OP_MUL: begin
`ifdef ALU_FAST_MUL_EN
        sc_res = operand_a * operand_b;
`else
        start_mul = 1'b1;
`endif
      end
      OP_DIV: begin
        if (operand_b == '0) begin
          sc_res = '1;
          sc_dbz = 1'b1;
        end else begin
          start_div = 1'b1;
        end
      end
      OP_AND: sc_res = operand_a & operand_b;
      OP_OR:  sc_res = operand_a | operand_b;
      OP_NOT: sc_res = ~operand_a;
      OP_SHL: sc_res = operand_a << operand_b[SHAMT_W-1:0];
      OP_SHR: sc_res = operand_a >> operand_b[SHAMT_W-1:0];
      OP_NOP: zn_en = 1'b0;
      default: begin
        zn_en  = 1'b0;
        sc_ill = 1'b1;
      end
    endcase
    sc_f.z = zn_en && (sc_res == '0);
    sc_f.n = zn_en && sc_res[M];
  end

  assign eng_step = (state == RUN_MUL) || (state == RUN_DIV);

  alu_seq_muldiv #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && (start_mul || start_div)),
    .is_div (start_div),
    .a      (operand_a),
    .b      (operand_b),
    .step   (eng_step),
    .last   (eng_last),
    .res    (eng_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      result_valid <= 1'b0;
      result       <= '0;
      flg          <= '0;
      div_by_zero  <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (result_valid && result_ready)
            result_valid <= 1'b0;
          if (accept) begin
            if (start_mul) begin
              state <= RUN_MUL;
            end else if (start_div) begin
              state <= RUN_DIV;
            end else begin
              result       <= sc_res;
              flg          <= sc_f;
              div_by_zero  <= sc_dbz;
              illegal_op   <= sc_ill;
              result_valid <= 1'b1;
            end
          end
        end
        RUN_MUL, RUN_DIV: begin
          if (eng_last)
            state <= DONE;
        end
        DONE: begin
          result       <= eng_res;
          flg.z        <= (eng_res == '0);
          flg.n        <= eng_res[M];
          flg.c        <= 1'b0;
          flg.v        <= 1'b0;
          div_by_zero  <= 1'b0;
          illegal_op   <= 1'b0;
          result_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign flag_z = flg.z;
  assign flag_n = flg.n;
  assign flag_c = flg.c;
  assign flag_v = flg.v;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (default build).
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [4:0]  alu_control = 5'b11111;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [31:0] result;
  logic        flag_z, flag_n, flag_c, flag_v;
  logic        div_by_zero;
  logic        illegal_op;
  logic [3:0]  fl;

  int checks = 0;
  int errors = 0;

  assign fl = {flag_z, flag_n, flag_c, flag_v};

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .alu_control  (alu_control),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .flag_c       (flag_c),
    .flag_v       (flag_v),
    .div_by_zero  (div_by_zero),
    .illegal_op   (illegal_op)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [4:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b);
    logic ok;
    ok = 1'b0;
    alu_control = op;
    operand_a   = a;
    operand_b   = b;
    op_valid    = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      ok = op_ready;
      @(posedge clk);
    end
    @(negedge clk);
    op_valid = 1'b0;
    if (!ok)
      check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic run1(input string tag,
                      input logic [4:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] exp_res,
                      input logic [3:0] exp_fl);
    send(op, a, b);
    check({tag, "_valid"}, 32'(result_valid), 32'd1);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flags"}, 32'(fl), 32'(exp_fl));
  endtask

  task automatic run_long(input string tag,
                          input logic [4:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] exp_res);
    int k;
    int low;
    k   = 0;
    low = 0;
    send(op, a, b);
    operand_a = 32'hDEAD_BEEF;
    operand_b = 32'h0000_0003;
    alu_control = 5'b00110;
    while (!result_valid && k < 200) begin
      if (!op_ready)
        low++;
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'd33);
    check({tag, "_busy"}, 32'(low), 32'd33);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flags"}, 32'(fl), 32'd0);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_flags", 32'(fl), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_ill", 32'(illegal_op), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(op_ready), 32'd1);

    run1("add_ovf", 5'b00110, 32'h7FFF_FFFF, 32'd1,
         32'h8000_0000, 4'b0101);
    run1("sub_eq", 5'b00111, 32'd5, 32'd5, 32'd0, 4'b1010);
    run1("cmp_lt", 5'b01110, 32'd3, 32'd7,
         32'hFFFF_FFFC, 4'b0100);
    run1("add_carry", 5'b00110, 32'hFFFF_FFFF, 32'd1,
         32'd0, 4'b1010);
    run1("and", 5'b01010, 32'h0000_F0F0, 32'h0000_FF00,
         32'h0000_F000, 4'b0000);
    run1("or", 5'b01011, 32'h0000_00F0, 32'h0000_000F,
         32'h0000_00FF, 4'b0000);
    run1("not", 5'b01111, 32'd0, 32'h1234_5678,
         32'hFFFF_FFFF, 4'b0100);
    run1("shl", 5'b01100, 32'd1, 32'h25, 32'h20, 4'b0000);
    run1("shr", 5'b01101, 32'h8000_0000, 32'h3F,
         32'd1, 4'b0000);

    run_long("mul", 5'b01000, 32'd1234, 32'd5678, 32'd7006652);
    run_long("div", 5'b01001, 32'd100, 32'd7, 32'd14);

    run1("div0", 5'b01001, 32'd9, 32'd0,
         32'hFFFF_FFFF, 4'b0100);
    check("div0_dbz", 32'(div_by_zero), 32'd1);
    run1("illegal", 5'b10101, 32'd4, 32'd4, 32'd0, 4'b0000);
    check("illegal_flag", 32'(illegal_op), 32'd1);
    run1("nop", 5'b11111, 32'd4, 32'd4, 32'd0, 4'b0000);
    check("nop_ill", 32'(illegal_op), 32'd0);

    // stall: result held while consumer is not ready
    send(5'b00110, 32'd2, 32'd3);
    result_ready = 1'b0;
    check("stall_first", result, 32'd5);
    alu_control = 5'b01011;
    operand_a   = 32'h0000_00F0;
    operand_b   = 32'h0000_000F;
    op_valid    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", 32'(op_ready), 32'd0);
      check("stall_res", result, 32'd5);
      check("stall_valid", 32'(result_valid), 32'd1);
    end
    result_ready = 1'b1;
    #1;
    check("stall_release", 32'(op_ready), 32'd1);
    @(negedge clk);
    op_valid = 1'b0;
    check("stall_next", result, 32'h0000_00FF);
    check("stall_next_v", 32'(result_valid), 32'd1);

    // reset in the middle of a divide aborts it
    send(5'b01001, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(op_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(result_valid), 32'd0);
    check("mid_rst_res", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 32'(op_ready), 32'd1);
    repeat (40) @(negedge clk);
    check("mid_no_result", 32'(result_valid), 32'd0);
    run1("post_rst_add", 5'b00110, 32'd1, 32'd1, 32'd2, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
